// File: rtl/sram_mem_controller.sv
// Two-phase controller for a 16-bit SRAM: each 32-bit load/store is split into a low and a high
// half-word access, with ready held low until the access is complete.
module sram_mem_controller #(
    parameter int DATA_WIDTH   = 32,
    parameter int SRAM_DW      = 16,
    parameter int SRAM_AW      = 18,
    parameter int BASE_ADDR    = 1024,
    parameter int PHASE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  ready,
    output logic [SRAM_AW-1:0]    SRAM_ADDR,
    output logic [SRAM_DW-1:0]    SRAM_DQ_out,
    input  logic [SRAM_DW-1:0]    SRAM_DQ_in,
    output logic                  SRAM_DQ_oe,
    output logic                  SRAM_WE_N
);
    localparam int CW = $clog2(PHASE_CYCLES);
    localparam int WW = SRAM_AW - 1;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WW-1:0]         word_q, word_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [WW-1:0] word_in;
    logic          last, hi;

    // Byte address -> half-word-pair index; out-of-range addresses wrap silently.
    assign word_in = WW'((address - DATA_WIDTH'(BASE_ADDR)) >> 2);
    assign last    = (cnt_q == CW'(PHASE_CYCLES - 1));
    assign hi      = (state_q == S_HI);
    assign readData = rdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        data_d      = data_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        case (state_q)
            S_IDLE: begin
                ready = !(wr_en | rd_en);
                if (wr_en | rd_en) begin
                    word_d  = word_in;
                    data_d  = writeData;
                    wr_d    = wr_en;
                    cnt_d   = '0;
                    state_d = S_LO;
                end
            end
            S_LO, S_HI: begin
                SRAM_ADDR = {word_q, hi};
                if (wr_q) begin
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_DQ_out = hi ? data_q[DATA_WIDTH-1:SRAM_DW] : data_q[SRAM_DW-1:0];
                    // Last cycle of a phase releases WE_N so address/data hold past the write edge.
                    SRAM_WE_N   = last;
                end
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    cnt_d = '0;
                    if (!wr_q) begin
                        if (hi) rdata_d[DATA_WIDTH-1:SRAM_DW] = SRAM_DQ_in;
                        else    rdata_d[SRAM_DW-1:0]          = SRAM_DQ_in;
                    end
                    state_d = hi ? S_DONE : S_HI;
                end
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            ready       = 1'b1;
            SRAM_ADDR   = '0;
            SRAM_DQ_out = '0;
            SRAM_DQ_oe  = 1'b0;
            SRAM_WE_N   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized bench for sram_mem_controller with an SRAM pin model and a word-level reference memory.
module tb_sram_mem_controller;
    localparam int P    = 2;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, writeData, readData;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
    logic        SRAM_DQ_oe, SRAM_WE_N;

    always #5 clk = ~clk;

    sram_mem_controller #(
        .DATA_WIDTH(32), .SRAM_DW(16), .SRAM_AW(18), .BASE_ADDR(BASE), .PHASE_CYCLES(P)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_in(SRAM_DQ_in), .SRAM_DQ_oe(SRAM_DQ_oe),
        .SRAM_WE_N(SRAM_WE_N)
    );

    // Asynchronous-read SRAM, written on the clock edge while WE_N is low.
    logic [15:0] sram [0:262143];
    initial for (int i = 0; i < 262144; i++) sram[i] = 16'h0;
    always @(posedge clk) if (SRAM_WE_N == 1'b0) sram[SRAM_ADDR] <= SRAM_DQ_out;
    assign SRAM_DQ_in = SRAM_DQ_oe ? 16'h0 : sram[SRAM_ADDR];

    int   pulses = 0;
    logic we_prev = 1'b1;
    always @(posedge clk) begin
        if (SRAM_WE_N == 1'b0 && we_prev == 1'b1) pulses++;
        we_prev <= SRAM_WE_N;
    end

    int checks = 0, failures = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_rd = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] word_of(input logic [31:0] a);
        logic [31:0] t;
        t = (a - 32'(BASE)) / 4;
        return t[16:0];
    endfunction

    // One held request, checked cycle by cycle from the issue cycle through the completion cycle.
    task automatic txn(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                       output logic [17:0] lo_addr);
        logic [16:0] wd;
        logic [17:0] eaddr;
        logic [15:0] edq;
        bit in_lo, in_hi, ewe;
        wd = word_of(a);
        lo_addr = '0;
        wr_en = w; rd_en = r; address = a; writeData = d;
        if (w) ref_mem[int'(wd)] = d;
        else   exp_rd = ref_mem.exists(int'(wd)) ? ref_mem[int'(wd)] : 32'h0;
        for (int c = 0; c <= 2*P+1; c++) begin
            @(negedge clk);
            in_lo = (c >= 1) && (c <= P);
            in_hi = (c > P) && (c <= 2*P);
            eaddr = in_lo ? {wd, 1'b0} : in_hi ? {wd, 1'b1} : 18'h0;
            ewe   = !(w && ((c >= 1 && c < P) || (c > P && c < 2*P)));
            edq   = !w ? 16'h0 : in_lo ? d[15:0] : in_hi ? d[31:16] : 16'h0;
            chk("ready",  32'(ready),       32'(c == 2*P+1));
            chk("addr",   32'(SRAM_ADDR),   32'(eaddr));
            chk("we_n",   32'(SRAM_WE_N),   32'(ewe));
            chk("oe",     32'(SRAM_DQ_oe),  32'(w && (in_lo || in_hi)));
            chk("dq_out", 32'(SRAM_DQ_out), 32'(edq));
            if (c == 1) lo_addr = SRAM_ADDR;
            if (c == 2*P+1) chk("readData", readData, exp_rd);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'h1);
            chk("idle_we_n",  32'(SRAM_WE_N), 32'h1);
            chk("idle_oe",    32'(SRAM_DQ_oe), 32'h0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [17:0] la;
        logic [31:0] a, d;
        int p0, op;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1032; writeData = 32'h0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready",    32'(ready), 32'h1);
            chk("rst_we_n",     32'(SRAM_WE_N), 32'h1);
            chk("rst_oe",       32'(SRAM_DQ_oe), 32'h0);
            chk("rst_readData", readData, 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        txn(0, 1, 32'd1032, 32'h0, la);

        p0 = pulses;
        txn(1, 0, 32'd1032, 32'hDEADBEEF, la);
        chk("wr_lo_addr", 32'(la), 32'd4);
        chk("wr_pulses", 32'(pulses - p0), 32'd2);
        txn(0, 1, 32'd1032, 32'h0, la);
        chk("rd_back", readData, 32'hDEADBEEF);

        p0 = pulses;
        txn(0, 1, 32'd1032, 32'h0, la);
        txn(1, 0, 32'd1036, 32'h12345678, la);
        chk("b2b_lo_addr", 32'(la), 32'd6);
        idle_check(4);
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);

        // Reset lands in the first high-half cycle of a write.
        p0 = pulses;
        wr_en = 1'b1; address = 32'd1032; writeData = 32'hCAFEF00D;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_ready", 32'(ready), 32'h1);
        chk("mrst_we_n",  32'(SRAM_WE_N), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("mrst_idle_ready", 32'(ready), 32'h1);
        chk("mrst_idle_we_n",  32'(SRAM_WE_N), 32'h1);
        chk("mrst_readData",   readData, 32'h0);
        chk("mrst_pulses",     32'(pulses - p0), 32'd1);
        chk("mrst_mem4",       32'(sram[4]), 32'h0000F00D);
        chk("mrst_mem5",       32'(sram[5]), 32'h0000DEAD);
        ref_mem[2] = 32'hDEADF00D;
        exp_rd = 32'h0;
        @(posedge clk); #1;
        txn(0, 1, 32'd1032, 32'h0, la);

        txn(1, 0, 32'd1020, 32'hA5A55A5A, la);
        chk("wrap_lo_addr", 32'(la), 32'h3FFFE);
        txn(1, 1, 32'd1040, 32'h0BADCAFE, la);
        chk("prio_readData", readData, 32'hDEADF00D);
        txn(0, 1, 32'd1040, 32'h0, la);
        txn(0, 1, 32'd1020, 32'h0, la);

        for (int i = 0; i < 30; i++) begin
            op = int'($urandom_range(0, 2));
            a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'(BASE) + 32'(4 * $urandom_range(0, 15));
            d  = $urandom;
            txn(op != 1, op != 0, a, d, la);
            if ($urandom_range(0, 1) == 1) idle_check(int'($urandom_range(1, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
